ifetch_unit: RTL and testbench

Decoupled instruction fetch front end for the 5-stage RV32I pipeline.
- Owns the fetch PC and issues sequential requests to instruction memory over a valid/ready request channel with an in-order, variable-latency response.
- Buffers returned instructions in a small FIFO and presents {instr, pc, pc+4} to the IF/DEC pipeline register through a valid/ready handshake.
- Accepts branch/jump redirects from EX (PCSrcE/PCTargetE). Flushes stale buffered and in-flight fetches.

---
 rtl/rv_pipe_pkg.sv | 24 ++
 rtl/ifetch_unit_if.sv | 32 +++
 rtl/ifetch_fifo.sv | 49 ++++
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32I 5-stage pipeline front end.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    HOLD,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential PC step; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response channel and decode handshake of the fetch unit.
interface ifetch_unit_if;
  import rv_pipe_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_plus4;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  dec_ready
  );

  // Memory and decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output dec_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; clear beats push and pop.
module ifetch_fifo
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy control; a clear discards any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; left unreset because only slots below count are ever presented.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Decoupled RV32I fetch front end: PC ownership, credit-limited imem requests,
// in-order response buffering, and redirect flush of buffered and in-flight words.
module ifetch_unit
  import rv_pipe_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  ifetch_unit_if.master     bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   out_after_rsp;
  logic [CW:0]     credit_used;
  logic            redirect_act;
  logic            req_fire;
  logic            rsp_take;
  logic            fifo_push;
  logic            fifo_pop;
  logic            has_entry;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Redirects are ignored during the post-reset HOLD cycle.
  assign redirect_act  = redirect_valid && (state != HOLD);
  // A response with nothing outstanding is a memory-side protocol slip and is dropped.
  assign rsp_take      = bus.imem_rsp_valid && (outstanding != '0);
  assign out_after_rsp = outstanding - CW'(rsp_take);
  // Buffered plus in-flight words may never exceed the FIFO size, so it cannot overflow.
  assign credit_used   = {1'b0, count} + {1'b0, outstanding};

  assign bus.imem_req_valid = (state != HOLD) && !redirect_valid &&
                              (outstanding < MAX_OUT_C) && (credit_used < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign fifo_push  = rsp_take && (drop_cnt == '0) && !redirect_act;
  assign fifo_pop   = has_entry && bus.dec_ready;
  assign push_entry = '{instr: bus.imem_rsp_data, pc: rsp_pc};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_act),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .count     (count),
    .head      (head)
  );

  // Decode outputs read the registered FIFO head; forced to zero while empty.
  assign has_entry        = (count != '0);
  assign bus.dec_valid    = has_entry;
  assign bus.dec_instr    = has_entry ? head.instr : '0;
  assign bus.dec_pc       = has_entry ? head.pc : '0;
  assign bus.dec_pc_plus4 = has_entry ? pc_step(head.pc) : '0;

  // Fetch FSM with PC, outstanding and drop bookkeeping; redirect overrides normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      fetch_pc    <= RESET_PC & WORD_MASK;
      rsp_pc      <= RESET_PC & WORD_MASK;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_act) begin
      fetch_pc    <= redirect_pc & WORD_MASK;
      rsp_pc      <= redirect_pc & WORD_MASK;
      outstanding <= out_after_rsp;
      drop_cnt    <= out_after_rsp;
      state       <= (out_after_rsp != '0) ? DRAIN : FETCH;
    end else begin
      outstanding <= out_after_rsp + CW'(req_fire);
      if (req_fire)  fetch_pc <= pc_step(fetch_pc);
      if (fifo_push) rsp_pc   <= pc_step(rsp_pc);
      case (state)
        HOLD:  state <= FETCH;
        FETCH: state <= FETCH;
        DRAIN: begin
          if (rsp_take) begin
            drop_cnt <= drop_cnt - 1'b1;
            if (drop_cnt == CW'(1)) state <= FETCH;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  // A stray response must never reach the buffer, and the credit bound must hold.
  assert property (@(posedge clk) disable iff (rst)
    (bus.imem_rsp_valid && (outstanding == '0)) |-> !fifo_push);
  assert property (@(posedge clk) disable iff (rst) credit_used <= DEPTH_C);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: variable-latency memory model plus hand-derived expectations.
module tb_ifetch_unit;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int epoch = 0;

  mem_ent_t    mem_q[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_instr[$];
  logic [31:0] dlv_pc4[$];

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_dec_valid;
  logic [31:0] s_dec_instr;
  logic [31:0] s_dec_pc;
  logic [31:0] s_dec_pc4;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Instruction word the memory returns for an address; epoch tags words issued before a reset.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {8'(8'hA0 + epoch), a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: present due response, sample outputs mid-cycle, log handshakes, advance.
  task automatic cycle();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_dec_valid = bus.dec_valid;
    s_dec_instr = bus.dec_instr;
    s_dec_pc    = bus.dec_pc;
    s_dec_pc4   = bus.dec_pc_plus4;
    if (s_req_valid && bus.imem_req_ready)
      mem_q.push_back('{due: cyc + lat, data: instr_of(s_req_addr)});
    if (s_dec_valid && bus.dec_ready && !redirect_valid && !rst) begin
      dlv_pc.push_back(s_dec_pc);
      dlv_instr.push_back(s_dec_instr);
      dlv_pc4.push_back(s_dec_pc4);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_dlv();
    dlv_pc.delete();
    dlv_instr.delete();
    dlv_pc4.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    epoch++;
    redirect_valid = 1'b0;
    bus.dec_ready = 1'b0;
    repeat (4) cycle();
    rst = 1'b0;
  endtask

  function automatic bit stale2(input bit need_dec);
    return (mem_q.size() == 2) && (mem_q[0].due > cyc) && (!need_dec || bus.dec_valid);
  endfunction

  // Wait until two requests are in flight and none answers this cycle.
  task automatic wait_stale2(input bit need_dec, input string tag);
    int n = 0;
    while (!stale2(need_dec) && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 32'(stale2(need_dec)), 32'd1);
  endtask

  function automatic bit rsp_and_pop();
    return bus.dec_valid && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  task automatic run_until_dlv(input int n, input string tag);
    int k = 0;
    while (dlv_pc.size() < n && k < 60) begin
      cycle();
      k++;
    end
    chk(tag, 32'(dlv_pc.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          first;
    int          nreq;
    int          bad;
    bit          seen;
    logic [31:0] first_addr;

    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b0;
    @(negedge clk);

    // Test 1: reset values, then 1-cycle memory streams one instruction per cycle.
    lat = 1;
    apply_reset();
    chk("rst_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("rst_dec_instr", s_dec_instr, 32'd0);
    chk("rst_dec_pc", s_dec_pc, 32'd0);
    chk("rst_dec_pc4", s_dec_pc4, 32'd0);
    bus.dec_ready = 1'b1;
    clear_dlv();
    first = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_dec_valid && first < 0) first = i;
    end
    chk("t1_first_valid", 32'(first), 32'd3);
    chk("t1_count", 32'(dlv_pc.size()), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pc%0d", i), dlv_pc[i], 32'(4 * i));
      chk($sformatf("t1_instr%0d", i), dlv_instr[i], instr_of(32'(4 * i)));
      chk($sformatf("t1_pc4_%0d", i), dlv_pc4[i], 32'(4 * i + 4));
    end

    // Test 2: decode stalled, credit stops fetch at DEPTH, then drain in order.
    apply_reset();
    lat = 1;
    bus.dec_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_req_valid && bus.imem_req_ready) nreq++;
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_req_stopped", 32'(s_req_valid), 32'd0);
    chk("t2_dec_valid", 32'(s_dec_valid), 32'd1);
    clear_dlv();
    bus.dec_ready = 1'b1;
    seen = 1'b0;
    first_addr = '1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_req_valid && !seen) begin
        seen = 1'b1;
        first_addr = s_req_addr;
      end
    end
    chk("t2_resume_addr", first_addr, 32'h10);
    run_until_dlv(6, "t2_dlv_timeout");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_pc%0d", i), dlv_pc[i], 32'(4 * i));
      chk($sformatf("t2_instr%0d", i), dlv_instr[i], instr_of(32'(4 * i)));
    end

    // Test 3: 3-cycle latency, two stale words in flight and a full-ish FIFO, redirect to 0x100.
    apply_reset();
    lat = 3;
    bus.dec_ready = 1'b0;
    wait_stale2(1'b1, "t3_setup");
    clear_dlv();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    chk("t3_no_req_in_redirect", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    bus.dec_ready = 1'b1;
    cycle();
    chk("t3_fifo_empty", 32'(s_dec_valid), 32'd0);
    run_until_dlv(2, "t3_dlv_timeout");
    chk("t3_pc0", dlv_pc[0], 32'h100);
    chk("t3_pc4_0", dlv_pc4[0], 32'h104);
    chk("t3_instr0", dlv_instr[0], instr_of(32'h100));
    chk("t3_pc1", dlv_pc[1], 32'h104);

    // Test 4: redirect coinciding with a response and a decode pop.
    apply_reset();
    lat = 1;
    bus.dec_ready = 1'b1;
    first = 0;
    while (!rsp_and_pop() && first < 40) begin
      cycle();
      first++;
    end
    chk("t4_setup", 32'(rsp_and_pop()), 32'd1);
    clear_dlv();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    cycle();
    chk("t4_no_req_in_redirect", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    cycle();
    chk("t4_req_valid", 32'(s_req_valid), 32'd1);
    chk("t4_req_addr", s_req_addr, 32'h80);
    run_until_dlv(2, "t4_dlv_timeout");
    chk("t4_pc0", dlv_pc[0], 32'h80);
    chk("t4_instr0", dlv_instr[0], instr_of(32'h80));
    chk("t4_pc1", dlv_pc[1], 32'h84);

    // Test 5: back-to-back redirects while draining; only the second target is delivered.
    apply_reset();
    lat = 3;
    bus.dec_ready = 1'b1;
    wait_stale2(1'b0, "t5_setup");
    clear_dlv();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    run_until_dlv(3, "t5_dlv_timeout");
    chk("t5_pc0", dlv_pc[0], 32'h300);
    chk("t5_instr0", dlv_instr[0], instr_of(32'h300));
    chk("t5_pc1", dlv_pc[1], 32'h304);
    chk("t5_pc2", dlv_pc[2], 32'h308);
    bad = 0;
    foreach (dlv_pc[i]) if (dlv_pc[i][31:8] == 24'h2) bad++;
    chk("t5_no_0x2xx", 32'(bad), 32'd0);

    // Test 6: reset with two requests in flight; their late answers must be ignored.
    apply_reset();
    lat = 3;
    bus.dec_ready = 1'b1;
    wait_stale2(1'b0, "t6_setup");
    rst = 1'b1;
    epoch++;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t6_req_valid", 32'(s_req_valid), 32'd0);
    chk("t6_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("t6_dec_pc", s_dec_pc, 32'd0);
    chk("t6_dec_instr", s_dec_instr, 32'd0);
    chk("t6_dec_pc4", s_dec_pc4, 32'd0);
    clear_dlv();
    seen = 1'b0;
    first_addr = '1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (s_req_valid) begin
        seen = 1'b1;
        first_addr = s_req_addr;
      end
    end
    chk("t6_restart_addr", first_addr, 32'h0);
    run_until_dlv(2, "t6_dlv_timeout");
    chk("t6_pc0", dlv_pc[0], 32'h0);
    chk("t6_instr0", dlv_instr[0], instr_of(32'h0));
    chk("t6_pc1", dlv_pc[1], 32'h4);
    chk("t6_instr1", dlv_instr[1], instr_of(32'h4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
